// File: rtl/da_tap_feeder_if.sv
// Sample-source handshake for da_tap_feeder: W-bit data with valid/ready flow control.
// The source drives through the master modport and the feeder receives through the slave modport.
interface da_tap_feeder_if #(
  parameter int W = 3
);
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/da_tap_feeder.sv
// Sample FIFO plus 3-tap delay line for the bit-serial DA FIR engine, with a frame-aligned load marker.
// Build option FEEDER_ZERO_FILL_EN: on underrun, shift a zero sample in instead of holding the taps.
module da_tap_feeder #(
  parameter int W      = 3,
  parameter int DEPTH  = 4,
  parameter int CYCLES = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  da_tap_feeder_if.slave           s,
  output logic [W-1:0]             x_in0,
  output logic [W-1:0]             x_in1,
  output logic [W-1:0]             x_in2,
  output logic                     da_load,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [AW:0]   L_FULL   = (AW + 1)'(DEPTH);
  localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES - 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level;
  logic [PW-1:0] r_ph;
  logic [W-1:0]  r_x0, r_x1, r_x2;
  logic          r_underrun, r_overflow;

  logic w_full, w_empty, w_ready, w_push, w_update, w_pop;

  assign w_full   = (r_level == L_FULL);
  assign w_empty  = (r_level == '0);
  assign w_ready  = reset & ~w_full;
  assign w_push   = s.s_valid & w_ready;
  assign w_update = (r_ph == PH_LAST);
  // The pop tests occupancy before this edge's push, so an empty FIFO never falls through.
  assign w_pop    = w_update & ~w_empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_ph <= '0;
    else if (w_update) r_ph <= '0;
    else               r_ph <= r_ph + 1'b1;
  end

  // NOTE: sample storage has no reset; the pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s.s_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x0 <= '0;
      r_x1 <= '0;
      r_x2 <= '0;
    end else if (w_pop) begin
      r_x2 <= r_x1;
      r_x1 <= r_x0;
      r_x0 <= r_mem[r_rd_ptr];
    end else if (w_update) begin
`ifdef FEEDER_ZERO_FILL_EN
      r_x2 <= r_x1;
      r_x1 <= r_x0;
      r_x0 <= '0;
`else
      r_x2 <= r_x2;
      r_x1 <= r_x1;
      r_x0 <= r_x0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_update && w_empty)      r_underrun <= 1'b1;
      if (s.s_valid && !w_ready)    r_overflow <= 1'b1;
    end
  end

  assign s.s_ready = w_ready;
  assign x_in0     = r_x0;
  assign x_in1     = r_x1;
  assign x_in2     = r_x2;
  assign da_load   = reset & (r_ph == '0);
  assign level     = r_level;
  assign underrun  = r_underrun;
  assign overflow  = r_overflow;

endmodule

// File: doc/da_tap_feeder.md
# da_tap_feeder

Upstream feeder for the 3-tap bit-serial distributed-arithmetic (DA) FIR engine. It accepts a stream of W-bit samples through a valid/ready handshake and buffers them in a small FIFO. It maintains the 3-tap delay line x[n], x[n-1], x[n-2] and presents the taps on x_in0..x_in2, updating them once per DA frame so they are stable at the engine's load edge. It also generates the frame-aligned load marker and sticky error flags for the engine's test bench.

## Interface

Parameters:
- W, 3, sample and tap width; matches the DA engine's x_in width.
- DEPTH, 4, input FIFO depth in samples; power of two, ≥2.
- CYCLES, 5, clocks per DA frame: one load cycle, W shift cycles and one output cycle.

Ports:
- clk  input  1  rising-edge clock shared with the DA engine.
- reset  input  1  asynchronous, active-low; asserted while 0; releases in step with the DA engine reset.
- s_data  input  W  sample from source.
- s_valid  input  1  s_data valid.
- s_ready  output  1  FIFO can accept a push; reset value 0.
- x_in0  output  W  newest tap x[n]; reset value 0.
- x_in1  output  W  tap x[n-1]; reset value 0.
- x_in2  output  W  tap x[n-2]; reset value 0.
- da_load  output  1  high during the cycle whose closing edge is a DA load edge; reset value 0.
- level  output  clog2(DEPTH)+1  FIFO occupancy; reset value 0.
- underrun  output  1  sticky: a tap update found the FIFO empty; reset value 0.
- overflow  output  1  sticky: s_valid was high while s_ready was low; reset value 0.

## Operation

- **Push:** a push occurs on an edge with s_valid=1 and s_ready=1.
  - s_ready = !full, forced 0 while reset is asserted.
  - A sample offered while full is dropped and sets overflow.
- **FIFO:** circular buffer with wr/rd pointers that wrap modulo DEPTH.
  - full when level==DEPTH; empty when level==0.
- **Phase counter:** ph counts 0..CYCLES-1 and wraps to 0. Reset value is 0.
- **da_load:** da_load = (ph==0) and reset deasserted.
- **Tap update:** occurs on the edge where ph==CYCLES-1.
  - FIFO non-empty: pop the head; x_in2<=x_in1, x_in1<=x_in0, x_in0<=head.
  - FIFO empty: set underrun; taps behave per Configuration.
- **Simultaneous push and pop:**
  - Not full: both happen and level is unchanged.
  - Full: the push is refused, because s_ready is already low. The pop proceeds and level becomes DEPTH-1.
  - Empty: the pop sees empty (no fall-through). The push lands and level becomes 1.
- **Flags:** underrun and overflow clear only on reset.
- **Reset mid-operation:** FIFO contents discarded; pointers, level, ph, taps and flags return to reset values immediately (asynchronous).
- **No arithmetic on samples:** taps are bit-exact copies of s_data.

## Timing

- Edge 1 is the first rising edge after reset release; ph after edge n = n mod CYCLES.
- DA load edges are 1, 1+CYCLES, 1+2·CYCLES, … The load at edge 1 takes all-zero taps.
- Tap update edges are CYCLES, 2·CYCLES, … Each is exactly one edge before a load edge, so taps are stable for the whole load cycle.
- Taps are held constant across all other edges of the frame.
- Latency, sample to x_in0: pushed at edge e into an empty FIFO, the sample appears after the first tap-update edge strictly later than e. The minimum is 1 edge, when e is immediately before an update edge.
- Throughput: one sample per CYCLES clocks. A source pushing faster fills the FIFO, and s_ready throttles it.
- level updates on the same edge as the push or pop. s_ready follows level combinationally.

## Configuration

- FEEDER_ZERO_FILL_EN
  - Defined: on underrun, a zero sample is shifted in (x_in2<=x_in1, x_in1<=x_in0, x_in0<=0), which keeps the delay line time-consistent.
  - Undefined: on underrun, all three taps hold their previous values.
  - In both cases underrun is set.

## Test plan

- **Reset state:** reset=0 for 3 cycles -> s_ready=0, da_load=0, x_in0..2=0, level=0, flags=0. Release -> s_ready=1 after release; da_load=1 in the cycle before edge 1.
- **Steady stream:** push 1,2,3,4 at edges 1–4, CYCLES=5 ->
  - after edge 5: x_in0/1/2 = 1/0/0
  - after edge 10: 2/1/0
  - after edge 15: 3/2/1
  - after edge 20: 4/3/2
  - underrun=0.
- **Full FIFO:** push 5,6,7,8,9 at edges 1–5 with s_valid held ->
  - samples 5–8 accepted; level=4 after edge 4.
  - 9 refused (s_ready=0) and overflow=1.
  - edge 5 pops 5, so level=3 and s_ready=1 after edge 5.
- **Simultaneous ops:** level=2, push on edge 10 (update edge) -> level stays 2, x_in0 = old head. Level=0, push on edge 10 -> underrun=1, level=1.
- **Underrun behaviour:** taps 3/2/1 with FIFO empty at the next update edge.
  - FEEDER_ZERO_FILL_EN defined -> 0/3/2.
  - Undefined -> 3/2/1.
  - underrun=1 in both builds.
- **Reset mid-frame:** assert reset at ph=2 with level=3 -> level=0, taps=0, flags=0 immediately. After release, the next tap update is at edge 5.
